seq_tx_0101: RTL and testbench
==============================

# seq_tx_0101

Serial frame transmitter for the team's serial link, on the transmit end of the line that the overlapping 0101 Mealy detector watches.
- Accepts a parallel word over a valid/ready handshake.
- Emits a fixed 0101 sync header, then the word MSB-first, one bit per clock.
- Holds the line at idle level 1 between frames, so the receiver sees a clean 0101 boundary.

## Interface
- DATA_W, 8, payload width in bits; must be ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  source offers `in_data`.
- in_data  input  DATA_W  payload word; sampled only on accept.
- in_ready  output  1  block can accept a word; equals (state==IDLE).
- dout  output  1  serial line, registered.
- dout_valid  output  1  high while a sync, data or parity bit is on `dout`.
- tx_done  output  1  one-cycle pulse during the GAP cycle of each frame.

## Operation
- **Accept:** a rising edge with `in_valid`=1 and `in_ready`=1.
  - `in_data` is loaded into the shift register.
  - The FSM leaves IDLE.
  - `in_valid` while `in_ready`=0 is ignored. There is no queue; the source holds `in_valid`.
- **FSM states:** IDLE → SYNC → DATA → [PAR] → GAP → IDLE.
  - IDLE: `dout`=1, `dout_valid`=0. On accept go to SYNC with `cnt`=0.
  - SYNC: `dout` = bit `cnt` of the sync sequence 0,1,0,1. After 4 bits go to DATA with `cnt`=0.
  - DATA: `dout` = shift-register MSB; shift left each clock. After DATA_W bits go to PAR if enabled, else GAP.
  - PAR (configurable): `dout` = even parity (XOR) of the accepted word, 1 cycle.
  - GAP: `dout`=1, `dout_valid`=0, `tx_done`=1, 1 cycle, then IDLE unconditionally.
- Changes to `in_data` after accept do not affect the frame in flight.
- **Counter:** `cnt` width is clog2(max(DATA_W,4)). It never wraps inside a state; it is cleared on every state change.
- **Reset (asynchronous, including mid-frame):**
  - Reset values: state=IDLE, `dout`=1, `dout_valid`=0, `tx_done`=0, shift register=0, `cnt`=0.
  - `in_ready` therefore reads 1 during reset, but no accept occurs while `rst`=1.
  - A partial frame is abandoned and no `tx_done` is issued.

## Timing
- Let accept edge be E0. The bit on `dout` after edge E0+n is:
  - n=1..4: sync bits 0,1,0,1.
  - n=5..4+DATA_W: data bits, MSB first.
  - n=5+DATA_W: parity bit (PAR only).
- GAP occupies the cycle after the last payload or parity bit. `in_ready` rises the cycle after GAP.
- Accept-to-accept minimum period:
  - DATA_W+6 cycles without PAR (14 at DATA_W=8).
  - DATA_W+7 cycles with PAR.
- `dout` is glitch-free and never X after reset.
- `dout_valid` is a contiguous high run of 4+DATA_W(+1) cycles per frame.

## Configuration
- Macro: SEQ_TX_PARITY_EN.
  - Defined: PAR state compiled in; one even-parity bit after the payload; frame and period grow by 1 cycle.
  - Undefined: PAR state and parity logic absent; DATA goes directly to GAP.

## Structure
- Package `seq_tx_pkg`:
  - State enum: IDLE, SYNC, DATA, PAR, GAP. PAR is present in the enum unconditionally for encoding stability.
  - SYNC_PATTERN = 4'b0101, SYNC_LEN = 4, IDLE_LEVEL = 1'b1.
- Sub-module `seq_tx_shifter`: DATA_W-bit load/shift-left register with a `load`/`shift` input pair and an MSB output.
- FSM, counter and output registers live in the top module.

## Test plan
- **Reset idle:** assert rst for 3 cycles with in_valid=0 → dout=1, dout_valid=0, in_ready=1, tx_done=0 throughout.
- **Single frame:** accept 8'hA5 (PAR off) →
  - dout reads 0,1,0,1,1,0,1,0,0,1,0,1 with dout_valid=1 for 12 cycles.
  - Then one GAP cycle: dout=1, tx_done=1.
  - in_ready returns 1 on the 14th cycle after accept.
- **Back-to-back:** hold in_valid=1 and present 8'h3C, then 8'hFF →
  - The second accept occurs exactly 14 cycles after the first.
  - Toggling in_data mid-frame does not change the serialized bits.
- **Mid-frame reset:** assert rst on cycle 7 after accepting 8'hF0 →
  - dout=1 and dout_valid=0 immediately.
  - No tx_done pulse.
  - The next accepted 8'h0F produces a clean 0101 + 00001111 frame.
- **Parity (SEQ_TX_PARITY_EN):**
  - 8'hA5 → parity bit 0 after the payload; frame of 13 valid bits; period 15.
  - 8'h07 → parity bit 1.
- **Ignored request:** pulse in_valid for 1 cycle during DATA with 8'h55 → not accepted; no second frame follows.

Source files
------------

// File: rtl/seq_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_tx_pkg                                                   |
// | Description : Shared types and constants for the seq_tx_0101 transmitter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seq_tx_pkg;

  // PAR stays in the encoding even when parity is compiled out.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b0101;
  localparam int         SYNC_LEN     = 4;
  localparam logic       IDLE_LEVEL   = 1'b1;

  function automatic int cnt_width(input int data_w);
    return (data_w > SYNC_LEN) ? $clog2(data_w) : $clog2(SYNC_LEN);
  endfunction

  // The pattern literal reads left to right in transmit order.
  function automatic logic sync_bit(input logic [1:0] idx);
    return SYNC_PATTERN[2'd3 - idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_tx_shifter                                               |
// | Description : Load / shift-left payload register with MSB tap.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] r_sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (load) begin
      r_sreg <= din;
    end else if (shift) begin
      r_sreg <= r_sreg << 1;
    end
  end

  assign msb = r_sreg[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/seq_tx_0101.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_tx_0101                                                  |
// | Description : Serial frame transmitter: 0101 sync header, MSB-first word,  |
// |               optional even parity bit (SEQ_TX_PARITY_EN), idle-high line. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_tx_0101
  import seq_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              tx_done
);

  localparam int                 c_CNT_W     = cnt_width(DATA_W);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(SYNC_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dout;
  logic               r_dout_valid;
  logic               r_tx_done;

  logic w_accept;
  logic w_shift;
  logic w_msb;

  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid & in_ready;
  assign w_shift    = (r_state == DATA);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign tx_done    = r_tx_done;

  seq_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (w_accept),
    .shift (w_shift),
    .din   (in_data),
    .msb   (w_msb)
  );

`ifdef SEQ_TX_PARITY_EN
  logic r_par;

  // Parity is captured with the word so later in_data changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^in_data;
    end
  end
`endif

  // Outputs are registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dout       <= IDLE_LEVEL;
      r_dout_valid <= 1'b0;
      r_tx_done    <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dout       <= IDLE_LEVEL;
          r_dout_valid <= 1'b0;
          r_cnt        <= '0;
          if (w_accept) begin
            r_state <= SYNC;
          end
        end
        SYNC: begin
          r_dout       <= sync_bit(r_cnt[1:0]);
          r_dout_valid <= 1'b1;
          if (r_cnt == c_SYNC_LAST) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        DATA: begin
          r_dout       <= w_msb;
          r_dout_valid <= 1'b1;
          if (r_cnt == c_DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
            r_state <= PAR;
`else
            r_state <= GAP;
`endif
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
`ifdef SEQ_TX_PARITY_EN
        PAR: begin
          r_dout       <= r_par;
          r_dout_valid <= 1'b1;
          r_state      <= GAP;
          r_cnt        <= '0;
        end
`endif
        GAP: begin
          r_dout       <= IDLE_LEVEL;
          r_dout_valid <= 1'b0;
          r_tx_done    <= 1'b1;
          r_state      <= IDLE;
          r_cnt        <= '0;
        end
        default: begin
          r_dout       <= IDLE_LEVEL;
          r_dout_valid <= 1'b0;
          r_state      <= IDLE;
          r_cnt        <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_tx_0101.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_tx_0101                                               |
// | Description : Directed self-checking bench for seq_tx_0101 (DATA_W=8).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_tx_0101;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       dout;
  logic       dout_valid;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_tx_0101 #(
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .tx_done    (tx_done)
  );

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
    logic        par;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [7:0] d, input bit hold);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  // mode 0: quiet inputs, 1: toggle in_data each cycle, 2: one-cycle in_valid pulse in DATA
  task automatic frame_check(input logic [11:0] frame, input logic par, input int mode,
                             input logic [7:0] next_d);
    chk("post_accept_dout", 32'(dout), 32'd1);
    chk("post_accept_valid", 32'(dout_valid), 32'd0);
    chk("post_accept_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("frame_bit", 32'(dout), 32'(frame[11-i]));
      chk("frame_valid", 32'(dout_valid), 32'd1);
      chk("frame_ready", 32'(in_ready), 32'd0);
      chk("frame_done", 32'(tx_done), 32'd0);
      if (mode == 1) in_data = ~in_data;
      if (mode == 2 && i == 6) begin
        in_valid = 1'b1;
        in_data  = 8'h55;
      end
      if (mode == 2 && i == 7) in_valid = 1'b0;
    end
`ifdef SEQ_TX_PARITY_EN
    tick();
    chk("parity_bit", 32'(dout), 32'(par));
    chk("parity_valid", 32'(dout_valid), 32'd1);
    chk("parity_ready", 32'(in_ready), 32'd0);
`endif
    tick();
    chk("gap_dout", 32'(dout), 32'd1);
    chk("gap_valid", 32'(dout_valid), 32'd0);
    chk("gap_done", 32'(tx_done), 32'd1);
    chk("gap_ready", 32'(in_ready), 32'd1);
    in_data = next_d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 12'b0101_1010_0101, par: 1'b0};
    vecs[1] = '{data: 8'h07, frame: 12'b0101_0000_0111, par: 1'b1};
    vecs[2] = '{data: 8'h81, frame: 12'b0101_1000_0001, par: 1'b0};
    vecs[3] = '{data: 8'h00, frame: 12'b0101_0000_0000, par: 1'b0};
    vecs[4] = '{data: 8'h01, frame: 12'b0101_0000_0001, par: 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_dout", 32'(dout), 32'd1);
      chk("reset_valid", 32'(dout_valid), 32'd0);
      chk("reset_ready", 32'(in_ready), 32'd1);
      chk("reset_done", 32'(tx_done), 32'd0);
    end
    rst = 1'b0;
    tick();

    foreach (vecs[k]) begin
      do_accept(vecs[k].data, 1'b0);
      frame_check(vecs[k].frame, vecs[k].par, 0, 8'h00);
    end

    // Back-to-back with in_valid held; the second accept must land on the first free edge.
    do_accept(8'h3C, 1'b1);
    frame_check(12'b0101_0011_1100, 1'b0, 1, 8'hFF);
    tick();
    in_valid = 1'b0;
    frame_check(12'b0101_1111_1111, 1'b0, 0, 8'h00);

    // Mid-frame reset at cycle 7 after accept.
    do_accept(8'hF0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_dout", 32'(dout), 32'd1);
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_done", 32'(tx_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_hold_done", 32'(tx_done), 32'd0);
      chk("midrst_hold_dout", 32'(dout), 32'd1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_done", 32'(tx_done), 32'd0);
      chk("postrst_valid", 32'(dout_valid), 32'd0);
    end
    do_accept(8'h0F, 1'b0);
    frame_check(12'b0101_0000_1111, 1'b0, 0, 8'h00);

    // A request pulse during DATA must be dropped.
    do_accept(8'h81, 1'b0);
    frame_check(12'b0101_1000_0001, 1'b0, 2, 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ignored_valid", 32'(dout_valid), 32'd0);
      chk("ignored_dout", 32'(dout), 32'd1);
      chk("ignored_ready", 32'(in_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
